fp16_result_packer: RTL and testbench

Pipelined normalize/round/pack stage that turns an unpacked FMA result (sign, unbiased exponent, wide unsigned magnitude) back into an IEEE-754 binary16 word. It is the output-side counterpart of the FP16 operand extractor. It sits after the Booth partial-product reduction and addend alignment of each FMA lane. It applies round-to-nearest-even, handles subnormal/overflow/special cases, and uses a valid/ready handshake toward the result collector.

---
 rtl/fp16_result_packer.sv | 172 +++++++++++++++++
 tb/tb_fp16_result_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_result_packer.sv
// Three-stage normalize / round-to-nearest-even / pack of an unpacked FMA result into binary16.
// One shared advance enable moves all stages together, so a stall freezes the whole pipe.
module fp16_result_packer #(
    parameter int MANT_W = 24,
    parameter int FRAC_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [7:0]        in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_nan,
    input  logic              in_inf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_inexact
);
    localparam int PW = $clog2(MANT_W);

    logic w_adv;

    // Stage 1 registers
    logic              r1_valid, r1_sign, r1_nan, r1_inf, r1_zero;
    logic [7:0]        r1_exp;
    logic [MANT_W-1:0] r1_mant;
    logic [PW-1:0]     r1_p;
    logic [PW-1:0]     w_lead;

    // Stage 2 registers
    logic              r2_valid, r2_sign, r2_nan, r2_inf, r2_zero, r2_sub;
    logic [9:0]        r2_exp;
    logic [10:0]       r2_sig;
    logic              r2_guard, r2_sticky;

    // Stage 3 (output) registers
    logic              r3_valid;
    logic [15:0]       r3_result;
    logic              r3_ovf, r3_unf, r3_inx;

    assign w_adv     = !r3_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r3_valid;
    assign out_result    = r3_result;
    assign out_overflow  = r3_ovf;
    assign out_underflow = r3_unf;
    assign out_inexact   = r3_inx;

    always_comb begin
        w_lead = '0;
        for (int i = 0; i < MANT_W; i++) begin
            if (in_mant[i]) w_lead = PW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_sign  <= in_sign;
            r1_exp   <= in_exp;
            r1_mant  <= in_mant;
            r1_nan   <= in_nan;
            r1_inf   <= in_inf;
            r1_zero  <= (in_mant == '0);
            r1_p     <= w_lead;
        end
    end

    // Stage 2: biased exponent, normalization, subnormal denormalization with sticky collection
    logic signed [9:0]  w_b;
    logic               w_sub;
    logic [3:0]         w_rsh;
    logic [MANT_W-1:0]  w_norm, w_den, w_mask;
    logic [10:0]        w_sig;
    logic               w_guard, w_sticky;

    always_comb begin
        w_b    = {{2{r1_exp[7]}}, r1_exp} + 10'(r1_p) - 10'(FRAC_W) + 10'd15;
        w_sub  = (w_b < 10'sd1);
        if (!w_sub)
            w_rsh = 4'd0;
        else if (w_b <= -10'sd11)
            w_rsh = 4'd12;
        else
            w_rsh = 4'(10'sd1 - w_b);
        w_norm   = r1_mant << (PW'(MANT_W - 1) - r1_p);
        w_mask   = ~({MANT_W{1'b1}} << w_rsh);
        w_den    = w_norm >> w_rsh;
        w_sig    = w_den[MANT_W-1 -: 11];
        w_guard  = w_den[MANT_W-12];
        w_sticky = (|w_den[MANT_W-13:0]) | (|(w_norm & w_mask));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
        end else if (w_adv) begin
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_nan    <= r1_nan;
            r2_inf    <= r1_inf;
            r2_zero   <= r1_zero;
            r2_sub    <= w_sub;
            r2_exp    <= w_sub ? 10'd0 : w_b;
            r2_sig    <= w_sig;
            r2_guard  <= w_guard;
            r2_sticky <= w_sticky;
        end
    end

    // Stage 3: RNE increment, carry renormalization, overflow, specials
    logic [11:0]        w_sum;
    logic signed [9:0]  w_exp_f;
    logic [9:0]         w_frac;
    logic               w_inx, w_ovf;
    logic [15:0]        w_result;
    logic               w_res_ovf, w_res_unf, w_res_inx;

    always_comb begin
        w_sum = {1'b0, r2_sig} + 12'(r2_guard & (r2_sticky | r2_sig[0]));
        if (r2_sub)
            w_exp_f = {9'd0, w_sum[10]};
        else if (w_sum[11])
            w_exp_f = r2_exp + 10'd1;
        else
            w_exp_f = r2_exp;
        w_frac = w_sum[11] ? 10'd0 : w_sum[9:0];
        w_inx  = r2_guard | r2_sticky;
        w_ovf  = (w_exp_f >= 10'sd31);

        w_result  = {r2_sign, w_exp_f[4:0], w_frac};
        w_res_ovf = 1'b0;
        w_res_inx = w_inx;
        w_res_unf = (w_exp_f == 10'sd0) && w_inx;
        if (r2_nan) begin
            w_result  = 16'h7E00;
            w_res_inx = 1'b0;
            w_res_unf = 1'b0;
        end else if (r2_inf || r2_zero) begin
            w_result  = {r2_sign, r2_inf ? 15'h7C00 : 15'h0000};
            w_res_inx = 1'b0;
            w_res_unf = 1'b0;
        end else if (w_ovf) begin
            w_result  = {r2_sign, 15'h7C00};
            w_res_ovf = 1'b1;
            w_res_inx = 1'b1;
            w_res_unf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r3_valid  <= 1'b0;
            r3_result <= 16'h0000;
            r3_ovf    <= 1'b0;
            r3_unf    <= 1'b0;
            r3_inx    <= 1'b0;
        end else if (w_adv) begin
            r3_valid  <= r2_valid;
            r3_result <= w_result;
            r3_ovf    <= w_res_ovf;
            r3_unf    <= w_res_unf;
            r3_inx    <= w_res_inx;
        end
    end
endmodule

// File: tb/tb_fp16_result_packer.sv
// Scoreboard bench for fp16_result_packer: an ulp-based rounding model predicts each word at accept time.
module tb_fp16_result_packer;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_sign, in_nan, in_inf;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic        out_valid, out_ready, out_overflow, out_underflow, out_inexact;
    logic [15:0] out_result;

    always #5 clk = ~clk;

    fp16_result_packer #(.MANT_W(24), .FRAC_W(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_nan(in_nan), .in_inf(in_inf),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    typedef struct packed {
        logic        ovf;
        logic        unf;
        logic        inx;
        logic [15:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   n_seen   = 0;
    logic acc;
    logic rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Result expressed as a count of ulps of the destination format, then rounded to nearest even
    function automatic exp_t model(input logic s, input logic [7:0] e, input logic [23:0] m,
                                   input logic nan, input logic inf);
        exp_t   r;
        longint se, msb, ee, k, d, sh, q, rem, half, n, fe;
        logic   inx;
        r   = '0;
        inx = 1'b0;
        if (nan) begin r.res = 16'h7E00; return r; end
        if (inf) begin r.res = {s, 15'h7C00}; return r; end
        if (m == 24'd0) begin r.res = {s, 15'h0000}; return r; end
        se  = longint'($signed(e));
        msb = 0;
        for (int i = 0; i < 24; i++) if (m[i]) msb = i;
        ee = se - 20 + msb;
        k  = ((ee < -14) ? -14 : ee) - 10;
        d  = se - 20 - k;
        if (d >= 0) begin
            n = longint'(m) << d;
        end else begin
            sh = -d;
            if (sh > 40) begin
                n   = 0;
                inx = 1'b1;
            end else begin
                q    = longint'(m) >> sh;
                rem  = longint'(m) - (q << sh);
                half = longint'(1) << (sh - 1);
                inx  = (rem != 0);
                n    = q + ((rem > half || (rem == half && q[0])) ? 1 : 0);
            end
        end
        if (n == 2048) begin n = 1024; k++; end
        fe = (n < 1024) ? 0 : k + 25;
        if (fe >= 31) begin
            r.res = {s, 15'h7C00};
            r.ovf = 1'b1;
            r.inx = 1'b1;
            return r;
        end
        r.res = {s, 5'(fe), n[9:0]};
        r.inx = inx;
        r.unf = (fe == 0) && inx;
        return r;
    endfunction

    // One clock: called at a negedge with inputs already driven
    task automatic cycle();
        exp_t e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = in_valid && in_ready;
        if (out_valid) begin
            n_seen++;
            check("out_has_expect", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                if (out_ready) begin
                    e = sb.pop_front();
                    $display("out %0d: result=%h ovf=%b unf=%b inx=%b", n_out, out_result,
                             out_overflow, out_underflow, out_inexact);
                    check("result",    32'(out_result),    32'(e.res));
                    check("overflow",  32'(out_overflow),  32'(e.ovf));
                    check("underflow", 32'(out_underflow), 32'(e.unf));
                    check("inexact",   32'(out_inexact),   32'(e.inx));
                    n_out++;
                end else begin
                    check("stall_hold", 32'(out_result), 32'(sb[0].res));
                end
            end
        end
        if (acc) sb.push_back(model(in_sign, in_exp, in_mant, in_nan, in_inf));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] m,
                         input logic nan, input logic inf);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_nan   = nan;
        in_inf   = inf;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic nan, input logic inf);
        drive(s, e, m, nan, inf);
        for (int t = 0; t < 200; t++) begin
            cycle();
            if (acc) break;
        end
        check("accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 100 && sb.size() > 0; t++) cycle();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat, idx, n0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_exp = 8'd0; in_mant = 24'd0; in_nan = 1'b0; in_inf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_result", 32'(out_result), 32'h0);
        check("rst_flags", 32'({out_overflow, out_underflow, out_inexact}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency into an empty pipe
        send(1'b0, 8'd0, 24'h100000, 1'b0, 1'b0);
        n0 = n_out;
        lat = 0;
        while (n_out == n0 && lat < 20) begin cycle(); lat++; end
        check("latency", 32'(lat), 32'd3);

        // Directed cases, back-to-back
        send(1'b0, 8'd0,           24'h180000, 1'b0, 1'b0);
        send(1'b1, 8'd1,           24'h100000, 1'b0, 1'b0);
        send(1'b0, 8'd0,           24'h100200, 1'b0, 1'b0);
        send(1'b0, 8'd0,           24'h100600, 1'b0, 1'b0);
        send(1'b0, 8'd16,          24'h100000, 1'b0, 1'b0);
        send(1'b0, 8'd15,          24'h1FFE00, 1'b0, 1'b0);
        send(1'b0, 8'd15,          24'h1FFC00, 1'b0, 1'b0);
        send(1'b0, 8'(-15),        24'h100000, 1'b0, 1'b0);
        send(1'b0, 8'(-24),        24'h100000, 1'b0, 1'b0);
        send(1'b0, 8'(-25),        24'h100000, 1'b0, 1'b0);
        send(1'b0, 8'(-15),        24'h1FFFFF, 1'b0, 1'b0);
        send(1'b1, 8'd3,           24'h000000, 1'b0, 1'b0);
        send(1'b0, 8'd0,           24'($urandom), 1'b1, 1'b0);
        send(1'b1, 8'd0,           24'h123456, 1'b0, 1'b1);
        send(1'b1, 8'd5,           24'($urandom), 1'b1, 1'b1);
        send(1'b0, 8'd127,         24'hFFFFFF, 1'b0, 1'b0);
        send(1'b1, 8'(-128),       24'hFFFFFF, 1'b0, 1'b0);
        send(1'b0, 8'd0,           24'h000001, 1'b0, 1'b0);
        drain();

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [23:0] m;
            m = 24'($urandom >> $urandom_range(8, 31));
            send(1'($urandom), 8'($urandom_range(0, 80)) - 8'd40, m,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        // Backpressure: five words offered over six stalled cycles
        n0 = n_out;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 8'(idx), 24'h100000 + 24'(idx) * 24'h1000, 1'b0, 1'b0);
            cycle();
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd3);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int t = 0; t < 50 && idx < 5; t++) begin
            drive(1'b0, 8'(idx), 24'h100000 + 24'(idx) * 24'h1000, 1'b0, 1'b0);
            cycle();
            if (acc) idx++;
        end
        drain();
        check("bp_count", 32'(n_out - n0), 32'd5);

        // Reset with three words in flight
        out_ready = 1'b0;
        send(1'b0, 8'd1, 24'h140000, 1'b0, 1'b0);
        send(1'b1, 8'd2, 24'h150000, 1'b0, 1'b0);
        send(1'b0, 8'd3, 24'h160000, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst2_out_valid",  32'(out_valid),  32'd0);
        check("rst2_out_result", 32'(out_result), 32'h0);
        check("rst2_flags", 32'({out_overflow, out_underflow, out_inexact}), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        n0 = n_seen;
        for (int t = 0; t < 8; t++) cycle();
        check("no_stale", 32'(n_seen - n0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
